// File: rtl/movegen_pkg.sv
// Shared constants and types for the movegen board shadow: board geometry,
// piece codes and the position-load state encoding.
package movegen_pkg;

  localparam int SQUARES = 64;
  localparam int SQ_W    = 6;
  localparam int PIECE_W = 4;

  typedef enum logic [PIECE_W-1:0] {
    EMPTY    = 4'd0,
    W_PAWN   = 4'd1,
    W_KNIGHT = 4'd2,
    W_BISHOP = 4'd3,
    W_ROOK   = 4'd4,
    W_QUEEN  = 4'd5,
    W_KING   = 4'd6,
    B_PAWN   = 4'd9,
    B_KNIGHT = 4'd10,
    B_BISHOP = 4'd11,
    B_ROOK   = 4'd12,
    B_QUEEN  = 4'd13,
    B_KING   = 4'd14
  } piece_e;

  typedef enum logic {
    LOAD_IDLE   = 1'b0,
    LOAD_ACTIVE = 1'b1
  } load_state_e;

endpackage

// File: rtl/movegen_board_shadow_if.sv
// Position stream, lookup request and lookup/occupancy result bundle of the
// board shadow; the master drives the stream and requests.
interface movegen_board_shadow_if
  import movegen_pkg::*;
#(
  parameter int NUM_LOOKUP = 2
) ();

  logic                          in_pos_valid;
  logic [PIECE_W-1:0]            in_pos_data;
  logic                          in_pos_sop;
  logic [NUM_LOOKUP-1:0]         lookup_valid;
  logic [NUM_LOOKUP*SQ_W-1:0]    lookup_rankfile;
  logic [NUM_LOOKUP-1:0]         out_valid;
  logic [NUM_LOOKUP*PIECE_W-1:0] out_piece;
  logic [SQUARES-1:0]            occupied;
  logic                          board_valid;
  logic [7:0]                    board_gen;
  logic                          frame_err;

  modport master (
    output in_pos_valid, in_pos_data, in_pos_sop, lookup_valid, lookup_rankfile,
    input  out_valid, out_piece, occupied, board_valid, board_gen, frame_err
  );

  modport slave (
    input  in_pos_valid, in_pos_data, in_pos_sop, lookup_valid, lookup_rankfile,
    output out_valid, out_piece, occupied, board_valid, board_gen, frame_err
  );

endinterface

// File: rtl/movegen_board_shadow_board_bank.sv
// One board bank: a square-indexed piece register file with a single write
// port, NUM_LOOKUP combinational read ports and a per-square non-empty view.
module board_bank
  import movegen_pkg::*;
#(
  parameter int NUM_LOOKUP = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [SQ_W-1:0]               wr_addr,
  input  logic [PIECE_W-1:0]            wr_data,
  input  logic [NUM_LOOKUP*SQ_W-1:0]    rd_addr,
  output logic [NUM_LOOKUP*PIECE_W-1:0] rd_data,
  output logic [SQUARES-1:0]            nonzero
);

  logic [PIECE_W-1:0] mem [SQUARES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SQUARES; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_LOOKUP; k++)
      rd_data[k*PIECE_W +: PIECE_W] = mem[rd_addr[k*SQ_W +: SQ_W]];
  end

  always_comb begin
    nonzero = '0;
    for (int i = 0; i < SQUARES; i++) nonzero[i] = (mem[i] != '0);
  end

endmodule

// File: rtl/movegen_board_shadow.sv
// Double-buffered board shadow: streams a position into the back bank and
// swaps banks atomically once all squares are written; lookups see only the active bank.
module movegen_board_shadow
  import movegen_pkg::*;
#(
  parameter int NUM_LOOKUP = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  movegen_board_shadow_if.slave bus
);

  localparam logic [SQ_W-1:0] LAST_SQ = SQ_W'(SQUARES - 1);

  load_state_e                   state, state_next;
  logic [SQ_W-1:0]               cnt, cnt_next;
  logic                          wr_en;
  logic [SQ_W-1:0]               wr_addr;
  logic                          commit;
  logic                          err_next;
  logic                          active;
  logic [SQUARES-1:0]            nz0, nz1, back_nz;
  logic [NUM_LOOKUP*PIECE_W-1:0] rd0, rd1, rd_active;

  // Bank 0 is the back bank while bank 1 is active, and vice versa.
  board_bank #(.NUM_LOOKUP(NUM_LOOKUP)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en && active),
    .wr_addr (wr_addr),
    .wr_data (bus.in_pos_data),
    .rd_addr (bus.lookup_rankfile),
    .rd_data (rd0),
    .nonzero (nz0)
  );

  board_bank #(.NUM_LOOKUP(NUM_LOOKUP)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en && !active),
    .wr_addr (wr_addr),
    .wr_data (bus.in_pos_data),
    .rd_addr (bus.lookup_rankfile),
    .rd_data (rd1),
    .nonzero (nz1)
  );

  assign rd_active = active ? rd1 : rd0;
  assign back_nz   = active ? nz0 : nz1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A sop beat always (re)starts a frame at square 0, even mid-load.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (bus.in_pos_valid) begin
      if (bus.in_pos_sop) begin
        state_next = LOAD_ACTIVE;
        cnt_next   = SQ_W'(1);
      end else if (state == LOAD_ACTIVE) begin
        if (cnt == LAST_SQ) begin
          state_next = LOAD_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_en    = bus.in_pos_valid && (bus.in_pos_sop || (state == LOAD_ACTIVE));
    wr_addr  = bus.in_pos_sop ? '0 : cnt;
    commit   = bus.in_pos_valid && !bus.in_pos_sop && (state == LOAD_ACTIVE) && (cnt == LAST_SQ);
    err_next = bus.in_pos_valid && (bus.in_pos_sop ? (state == LOAD_ACTIVE) : (state == LOAD_IDLE));
  end

  // The bank swap lands on the same edge as the last write, so a sop in the
  // very next cycle already targets the freshly retired bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active          <= 1'b0;
      bus.board_valid <= 1'b0;
      bus.board_gen   <= '0;
      bus.occupied    <= '0;
      bus.frame_err   <= 1'b0;
      bus.out_valid   <= '0;
      bus.out_piece   <= '0;
    end else begin
      bus.frame_err <= err_next;
      if (commit) begin
        active          <= ~active;
        bus.board_valid <= 1'b1;
        bus.board_gen   <= bus.board_gen + 8'd1;
        bus.occupied    <= {bus.in_pos_data != '0, back_nz[SQUARES-2:0]};
      end
      bus.out_valid <= bus.lookup_valid;
      for (int k = 0; k < NUM_LOOKUP; k++) begin
        if (bus.lookup_valid[k])
          bus.out_piece[k*PIECE_W +: PIECE_W] <= rd_active[k*PIECE_W +: PIECE_W];
      end
    end
  end

endmodule

// File: tb/tb_movegen_board_shadow.sv
// Randomized self-checking bench for movegen_board_shadow against a
// frame-level model of the committed board, lookups and error pulses.
module tb_movegen_board_shadow;
  import movegen_pkg::*;

  localparam int NL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  movegen_board_shadow_if #(.NUM_LOOKUP(NL)) bus ();

  movegen_board_shadow #(.NUM_LOOKUP(NL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [PIECE_W-1:0] m_active [SQUARES];
  logic [PIECE_W-1:0] m_back   [SQUARES];
  int                 m_pos;
  int                 m_gen;
  bit                 m_bv;
  logic [PIECE_W-1:0] exp_piece [NL];
  logic [NL-1:0]      exp_valid;
  bit                 exp_err;
  logic [PIECE_W-1:0] frame_buf [SQUARES];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] modelOccupancy();
    logic [63:0] occ;
    for (int i = 0; i < SQUARES; i++) occ[i] = (m_active[i] != 0);
    return occ;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < SQUARES; i++) begin
      m_active[i] = '0;
      m_back[i]   = '0;
    end
    for (int k = 0; k < NL; k++) exp_piece[k] = '0;
    exp_valid = '0;
    exp_err   = 1'b0;
    m_pos     = -1;
    m_gen     = 0;
    m_bv      = 1'b0;
  endtask

  // One clock cycle: drive, predict from the frame-level model, then compare.
  task automatic applyStimulus(input bit v, input bit s, input logic [PIECE_W-1:0] d,
                               input logic [NL-1:0] lv, input logic [NL*SQ_W-1:0] lrf);
    logic [PIECE_W-1:0] tmp;
    @(negedge clk);
    bus.in_pos_valid    = v;
    bus.in_pos_sop      = s;
    bus.in_pos_data     = d;
    bus.lookup_valid    = lv;
    bus.lookup_rankfile = lrf;
    exp_valid = lv;
    for (int k = 0; k < NL; k++)
      if (lv[k]) exp_piece[k] = m_active[int'(lrf[k*SQ_W +: SQ_W])];
    exp_err = 1'b0;
    if (v) begin
      if (s) begin
        exp_err   = (m_pos != -1);
        m_back[0] = d;
        m_pos     = 1;
      end else if (m_pos == -1) begin
        exp_err = 1'b1;
      end else begin
        m_back[m_pos] = d;
        m_pos++;
        if (m_pos == SQUARES) begin
          for (int i = 0; i < SQUARES; i++) begin
            tmp         = m_active[i];
            m_active[i] = m_back[i];
            m_back[i]   = tmp;
          end
          m_gen = (m_gen + 1) % 256;
          m_bv  = 1'b1;
          m_pos = -1;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput("out_valid", bus.out_valid, exp_valid);
    for (int k = 0; k < NL; k++)
      checkOutput($sformatf("out_piece%0d", k), bus.out_piece[k*PIECE_W +: PIECE_W], exp_piece[k]);
    checkOutput("occupied", bus.occupied, modelOccupancy());
    checkOutput("board_valid", bus.board_valid, m_bv);
    checkOutput("board_gen", bus.board_gen, m_gen[7:0]);
    checkOutput("frame_err", bus.frame_err, exp_err);
  endtask

  task automatic randLookups(input int fix_sq, output logic [NL-1:0] lv, output logic [NL*SQ_W-1:0] lrf);
    for (int k = 0; k < NL; k++) begin
      lv[k] = 1'($urandom_range(0, 1));
      lrf[k*SQ_W +: SQ_W] = SQ_W'($urandom_range(0, SQUARES - 1));
    end
    if (fix_sq >= 0) begin
      lv[0]          = 1'b1;
      lrf[0 +: SQ_W] = SQ_W'(fix_sq);
    end
  endtask

  task automatic sendBeat(input bit s, input logic [PIECE_W-1:0] d, input int gap_pct, input int fix_sq);
    logic [NL-1:0]      lv;
    logic [NL*SQ_W-1:0] lrf;
    for (int g = 0; g < 3; g++) begin
      if ($urandom_range(0, 99) >= gap_pct) break;
      randLookups(fix_sq, lv, lrf);
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), PIECE_W'($urandom_range(0, 15)), lv, lrf);
    end
    randLookups(fix_sq, lv, lrf);
    applyStimulus(1'b1, s, d, lv, lrf);
  endtask

  task automatic streamBeats(input int first, input int last, input int gap_pct, input int fix_sq);
    for (int i = first; i <= last; i++) sendBeat(i == 0, frame_buf[i], gap_pct, fix_sq);
  endtask

  task automatic fillRandom();
    for (int i = 0; i < SQUARES; i++)
      frame_buf[i] = ($urandom_range(0, 99) < 40) ? '0 : PIECE_W'($urandom_range(1, 15));
  endtask

  task automatic fillStart();
    piece_e back_w [8];
    piece_e back_b [8];
    back_w = '{W_ROOK, W_KNIGHT, W_BISHOP, W_QUEEN, W_KING, W_BISHOP, W_KNIGHT, W_ROOK};
    back_b = '{B_ROOK, B_KNIGHT, B_BISHOP, B_QUEEN, B_KING, B_BISHOP, B_KNIGHT, B_ROOK};
    for (int i = 0; i < SQUARES; i++) frame_buf[i] = EMPTY;
    for (int f = 0; f < 8; f++) begin
      frame_buf[f]      = back_w[f];
      frame_buf[8 + f]  = W_PAWN;
      frame_buf[48 + f] = B_PAWN;
      frame_buf[56 + f] = back_b[f];
    end
  endtask

  // Reset is raised between clock edges so its asynchronous effect is visible at once.
  task automatic doReset();
    @(negedge clk);
    #2;
    rst                 = 1'b1;
    bus.in_pos_valid    = 1'b0;
    bus.in_pos_sop      = 1'b0;
    bus.in_pos_data     = '0;
    bus.lookup_valid    = '0;
    bus.lookup_rankfile = '0;
    #1;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_piece", bus.out_piece, 0);
    checkOutput("rst_occupied", bus.occupied, 0);
    checkOutput("rst_board_valid", bus.board_valid, 0);
    checkOutput("rst_board_gen", bus.board_gen, 0);
    checkOutput("rst_frame_err", bus.frame_err, 0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int gen_before;
    int frames;
    logic [NL*SQ_W-1:0] lrf;

    bus.in_pos_valid    = 1'b0;
    bus.in_pos_sop      = 1'b0;
    bus.in_pos_data     = '0;
    bus.lookup_valid    = '0;
    bus.lookup_rankfile = '0;
    doReset();

    // Stray beat with no sop straight out of reset.
    applyStimulus(1'b1, 1'b0, 4'h5, NL'(1), '0);
    checkOutput("stray_err", bus.frame_err, 1);
    applyStimulus(1'b0, 1'b0, 4'h0, NL'(1), '0);
    checkOutput("stray_bv", bus.board_valid, 0);
    checkOutput("stray_valid0", bus.out_valid[0], 1);
    checkOutput("stray_piece0", bus.out_piece[PIECE_W-1:0], 0);

    // Standard start position.
    fillStart();
    streamBeats(0, SQUARES - 1, 20, -1);
    lrf = '0;
    lrf[0*SQ_W +: SQ_W] = SQ_W'(4);
    lrf[1*SQ_W +: SQ_W] = SQ_W'(60);
    lrf[2*SQ_W +: SQ_W] = SQ_W'(20);
    applyStimulus(1'b0, 1'b0, 4'h0, NL'(7), lrf);
    checkOutput("start_sq4", bus.out_piece[0*PIECE_W +: PIECE_W], 6);
    checkOutput("start_sq60", bus.out_piece[1*PIECE_W +: PIECE_W], 14);
    checkOutput("start_sq20", bus.out_piece[2*PIECE_W +: PIECE_W], 0);
    checkOutput("start_occ", bus.occupied, 64'hFFFF00000000FFFF);
    checkOutput("start_gen", bus.board_gen, 1);

    // Second frame while port 0 watches square 12 across the commit.
    fillRandom();
    frame_buf[12] = W_QUEEN;
    lrf = '0;
    lrf[0 +: SQ_W] = SQ_W'(12);
    for (int i = 0; i < SQUARES; i++) applyStimulus(1'b1, i == 0, frame_buf[i], NL'(1), lrf);
    checkOutput("sq12_commit_cycle", bus.out_piece[PIECE_W-1:0], 1);
    applyStimulus(1'b0, 1'b0, 4'h0, NL'(1), lrf);
    checkOutput("sq12_after_commit", bus.out_piece[PIECE_W-1:0], 5);

    // Truncated frame: sop again at beat 30, then a complete frame.
    gen_before = m_gen;
    fillRandom();
    streamBeats(0, 29, 0, -1);
    fillRandom();
    sendBeat(1'b1, frame_buf[0], 0, -1);
    checkOutput("trunc_err", bus.frame_err, 1);
    streamBeats(1, SQUARES - 1, 25, -1);
    checkOutput("trunc_gen", bus.board_gen, 8'((gen_before + 1) % 256));

    // Random gapped frames with random lookups.
    for (int f = 0; f < 4; f++) begin
      fillRandom();
      streamBeats(0, SQUARES - 1, 30, -1);
    end

    // All ports on square 63 with gapped request valids.
    lrf = '0;
    for (int k = 0; k < NL; k++) lrf[k*SQ_W +: SQ_W] = SQ_W'(63);
    for (int c = 0; c < 24; c++) applyStimulus(1'b0, 1'b0, 4'h0, NL'($urandom_range(0, (1 << NL) - 1)), lrf);

    // Back-to-back frames up to the board_gen wrap.
    frames = 256 - m_gen;
    for (int f = 0; f < frames; f++) begin
      fillRandom();
      streamBeats(0, SQUARES - 1, 0, -1);
    end
    checkOutput("wrap_gen", bus.board_gen, 0);
    checkOutput("wrap_bv", bus.board_valid, 1);

    // Reset in the middle of a frame, then a fresh full frame.
    fillRandom();
    streamBeats(0, 39, 10, -1);
    doReset();
    fillRandom();
    streamBeats(0, SQUARES - 1, 10, -1);
    applyStimulus(1'b0, 1'b0, 4'h0, '0, '0);
    checkOutput("post_rst_gen", bus.board_gen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/movegen_board_shadow.md
Name: movegen_board_shadow

Overview:
- Double-buffered shadow copy of the chess board for the move generator.
- Captures a streamed position (one piece code per square, sop-marked) into a back bank, then commits it atomically.
- Serves NUM_LOOKUP independent registered piece lookups plus a 64-bit occupancy map from the committed bank.
- Lookups never observe a partially loaded board. Sits between the position stream and the movegen lookup/ray stages.

Parameters:
- NUM_LOOKUP, 2, number of independent lookup ports (1..8)
- PIECE_W, 4, width of a piece code; code 0 = empty square
- SQUARES, 64, squares per position; index = rank*8+file, a1=0, h8=63
- SQ_W, 6, square index width, equal to log2(SQUARES)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_pos_valid  in  1  position beat valid
- in_pos_data  in  PIECE_W  piece code for the current square
- in_pos_sop  in  1  first beat of a position (square 0); qualified by in_pos_valid
- lookup_valid  in  NUM_LOOKUP  per-port lookup request
- lookup_rankfile  in  NUM_LOOKUP*SQ_W  per-port square index, port k at [k*SQ_W +: SQ_W]
- out_valid  out  NUM_LOOKUP  per-port result valid
- out_piece  out  NUM_LOOKUP*PIECE_W  per-port piece code, same packing
- occupied  out  SQUARES  bit i set when committed square i is non-zero
- board_valid  out  1  a complete position has been committed since reset
- board_gen  out  8  commit counter, wraps 255->0
- frame_err  out  1  one-cycle pulse on a malformed frame

Behaviour:
- Reset (async assert, sync release): both banks cleared to 0; active bank = 0; load counter idle; all outputs 0.
- Beat acceptance: a beat is accepted only when in_pos_valid=1. in_pos_sop and in_pos_data are ignored when in_pos_valid=0.
- Load FSM, IDLE:
  - sop beat: write the square 0 into the back bank, cnt=1, go to LOAD.
  - non-sop beat: dropped; frame_err pulse.
- Load FSM, LOAD:
  - non-sop beat: write square cnt into the back bank, then cnt++.
  - When the beat written is square SQUARES-1: commit, go to IDLE.
  - sop beat in LOAD (truncated frame): frame_err pulse; restart the frame, writing this beat as square 0 with cnt=1. The back bank holds stale squares, which is permitted because a commit requires all 64 writes.
- Commit, registered in the cycle after the last beat:
  - active bank toggles; board_valid=1; board_gen increments.
- Beats between a commit and the next sop are handled by IDLE rules (dropped, frame_err).
- Back-to-back frames are supported: a sop beat may arrive in the cycle immediately after the last beat. The new frame writes the bank that has just become the back bank.
- Lookup, 1-cycle latency:
  - out_piece[k] and out_valid[k] register the active-bank content at lookup_rankfile[k] when lookup_valid[k]=1.
  - out_valid[k]=0 otherwise; out_piece[k] holds its last value.
- Lookup vs commit: a lookup issued in the same cycle the commit register updates reads the old bank. Lookups from the following cycle read the new bank.
- Lookup before any commit returns 0 with out_valid=1.
- Ports are fully independent. Any ports may hit the same square in the same cycle.
- occupied: registered, updated in the commit cycle together with the bank toggle, so it is always consistent with the active bank.
- rst mid-frame: aborts the load and returns to the full reset state. No commit occurs; board_gen returns to 0.

Decomposition:
- movegen_pkg holds: SQUARES, SQ_W, PIECE_W, the piece code enum (EMPTY=0, white P/N/B/R/Q/K=1..6, black = 9..14), and the load FSM state typedef.
- Sub-module board_bank: SQUARES x PIECE_W register file with one write port and NUM_LOOKUP combinational read ports. It is instantiated twice.
- The top level holds the load FSM, bank select, output registers and occupancy.

Test Plan:
- Standard start position streamed as 64 beats with sop on beat 0. Then look up squares 4, 60 and 20 -> pieces 6, 14 and 0, valid one cycle later; occupied=0xFFFF00000000FFFF; board_gen=1.
- Second frame streamed while port 0 repeatedly looks up square 12. Returns the old piece through the commit cycle, and the new piece from the cycle after; no mixed values.
- sop reasserted at beat 30 of a frame. frame_err pulses once, no commit occurs at the old beat 63, and the restarted frame commits after 64 beats (board_gen +1 only).
- Stray valid beat with no sop after reset. frame_err pulses, board_valid stays 0, and a lookup of square 0 returns 0.
- NUM_LOOKUP=4 with all ports on square 63 plus gapped valid. Correct per-port results; idle ports have out_valid=0 and hold their prior data.
- rst asserted at beat 40 of a frame. All outputs are 0 immediately; a following full frame commits with board_gen=1.
